// File: rtl/xoro_stream_checker_pkg.sv
// Shared types and constants for the xoroshiro128+ stream checker.
package xoro_stream_checker_pkg;

    // Checker phases: seed load, expecting the low word, expecting the high word
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        EXP_LO = 2'd1,
        EXP_HI = 2'd2
    } state_t;

    // xoroshiro128+ rotation and shift amounts
    localparam int ROT_S0  = 24;
    localparam int SHIFT_T = 16;
    localparam int ROT_T   = 37;

    // Counter widths
    localparam int PAIR_W = 32;
    localparam int ERR_W  = 16;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Rotate a 64-bit word left by a constant amount in 1..63
    function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

endpackage

// File: rtl/xoro_stream_checker_if.sv
// Valid/ready word stream carrying the 32-bit halves of each 64-bit sample.
interface xoro_stream_checker_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/xoro_stream_checker_step.sv
// Combinational xoroshiro128+ step, shared by checker and generator designs.
module xoro_step
    import xoro_stream_checker_pkg::*;
(
    input  logic [63:0] s0,
    input  logic [63:0] s1,
    output logic [63:0] s0_next,
    output logic [63:0] s1_next,
    output logic [63:0] sum
);

    logic [63:0] t;

    // Output of the current state and the following state
    always_comb begin
        t       = s0 ^ s1;
        s0_next = rotl64(s0, ROT_S0) ^ t ^ (t << SHIFT_T);
        s1_next = rotl64(t, ROT_T);
        sum     = s0 + s1;
    end

endmodule

// File: rtl/xoro_stream_checker.sv
// Checks an incoming word stream against a local xoroshiro128+ generator,
// counting samples and mismatching samples.
module xoro_stream_checker
    import xoro_stream_checker_pkg::*;
#(
    parameter logic [63:0] SEED0 = 64'h0000_0000_0000_0001,
    parameter logic [63:0] SEED1 = 64'h0000_0000_0000_0002
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    xoro_stream_checker_if.slave   in_bus,
    output logic [PAIR_W-1:0]      pair_count,
    output logic [ERR_W-1:0]       err_count,
    output logic                   mismatch,
    output logic                   first_err
);

    state_t      state;
    state_t      state_next;
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s0_next;
    logic [63:0] s1_next;
    logic [63:0] sum;
    logic        lo_bad;
    logic        ready;
    logic        accept_lo;
    logic        accept_hi;
    logic        sample_bad;

    xoro_step step (
        .s0      (s0),
        .s1      (s1),
        .s0_next (s0_next),
        .s1_next (s1_next),
        .sum     (sum)
    );

    assign in_bus.in_ready = ready;
    assign sample_bad      = lo_bad || (in_bus.in_data != sum[63:32]);

    // State register; reset parks the checker in LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state, ready and accept decode; clear overrides any handshake
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        accept_lo  = 1'b0;
        accept_hi  = 1'b0;
        case (state)
            LOAD: begin
                state_next = EXP_LO;
            end
            EXP_LO: begin
                ready = 1'b1;
                if (in_bus.in_valid && !clear) begin
                    accept_lo  = 1'b1;
                    state_next = EXP_HI;
                end
            end
            EXP_HI: begin
                ready = 1'b1;
                if (in_bus.in_valid && !clear) begin
                    accept_hi  = 1'b1;
                    state_next = EXP_LO;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
        if (clear) begin
            state_next = LOAD;
        end
    end

    // Generator state, low-half verdict and counters; clear behaves like reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0         <= SEED0;
            s1         <= SEED1;
            lo_bad     <= 1'b0;
            pair_count <= '0;
            err_count  <= '0;
            mismatch   <= 1'b0;
            first_err  <= 1'b0;
        end else if (clear) begin
            s0         <= SEED0;
            s1         <= SEED1;
            lo_bad     <= 1'b0;
            pair_count <= '0;
            err_count  <= '0;
            mismatch   <= 1'b0;
            first_err  <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (accept_lo) begin
                lo_bad <= (in_bus.in_data != sum[31:0]);
            end
            if (accept_hi) begin
                s0         <= s0_next;
                s1         <= s1_next;
                pair_count <= pair_count + PAIR_W'(1);
                if (sample_bad) begin
                    mismatch  <= 1'b1;
                    first_err <= 1'b1;
                    if (err_count != ERR_MAX) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/xoro_stream_checker.md
XORO_STREAM_CHECKER -- requirements
Module: xoro_stream_checker

Interface
REQ-001 SHALL have parameter SEED0, default 64'h0000_0000_0000_0001, initial xoroshiro128+ state word s0.
REQ-002 SHALL have parameter SEED1, default 64'h0000_0000_0000_0002, initial xoroshiro128+ state word s1.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous reseed and counter clear.
REQ-006 SHALL have port in_valid  input  1  in_data holds a word.
REQ-007 SHALL have port in_ready  output  1  checker accepts a word this cycle.
REQ-008 SHALL have port in_data  input  32  received word: low half of a 64-bit sample first, then high half.
REQ-009 SHALL have port pair_count  output  32  completed 64-bit samples checked, wraps modulo 2^32.
REQ-010 SHALL have port err_count  output  16  mismatching samples, saturating at 16'hFFFF.
REQ-011 SHALL have port mismatch  output  1  one-cycle pulse per mismatching sample.
REQ-012 SHALL have port first_err  output  1  sticky: at least one mismatch since reset/clear.

Function
REQ-013 SHALL use the FSM states LOAD, EXP_LO, EXP_HI.
REQ-014 A word SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 0 in LOAD and 1 in EXP_LO and EXP_HI.
REQ-016 LOAD SHALL go to EXP_LO unconditionally after one cycle.
REQ-017 Expected sample SHALL be (s0 + s1) mod 2^64.
REQ-018 On accept in EXP_LO: compare in_data with expected[31:0], register the result as lo_bad, go to EXP_HI.
REQ-019 On accept in EXP_HI: compare in_data with expected[63:32], then go to EXP_LO.
- The sample is bad if lo_bad or the high half differs.
- Advance the PRNG state, increment pair_count.
REQ-020 PRNG advance SHALL be: t = s1 ^ s0; s0' = rotl64(s0,24) ^ t ^ (t << 16); s1' = rotl64(t,37).
REQ-021 State SHALL NOT change when no word is accepted; in_valid gaps of any length SHALL be tolerated in either EXP state.
REQ-022 For a bad sample, mismatch SHALL be 1 in the cycle after the high-word accept, and 0 otherwise.
REQ-023 For a bad sample, err_count SHALL increment (unless already 16'hFFFF) in that same cycle, and first_err SHALL set.
REQ-024 pair_count SHALL update in the cycle after the high-word accept; 32'hFFFF_FFFF SHALL wrap to 0.
REQ-025 clear=1 SHALL take priority over a simultaneous accept: the word is discarded.
- State SHALL go to LOAD, with s0/s1 reloaded from SEED0/SEED1.
- Counters, first_err and lo_bad SHALL be zeroed, and the mismatch pulse suppressed.
REQ-026 clear held for several cycles SHALL keep the block in LOAD with in_ready=0.

Reset
REQ-027 reset=1 SHALL immediately apply:
- state LOAD, s0=SEED0, s1=SEED1, lo_bad=0;
- in_ready=0, pair_count=0, err_count=0, mismatch=0, first_err=0.
REQ-028 Reset asserted mid-sample (in EXP_HI) SHALL discard the half-received sample; after release, checking restarts at the first seed output.
REQ-029 The first accept SHALL be possible no earlier than the second rising edge after reset release.

Structure
REQ-030 A shared package SHALL hold:
- the state enumeration;
- rotation constants 24, 16, 37;
- the counter widths.
REQ-031 The PRNG step SHALL be a combinational sub-module xoro_step: inputs s0, s1; outputs s0', s1' and the sum.
- The step SHALL also be reusable by the generator side.

Verification
REQ-032 Default seeds, continuous valid, words 0x00000003, 0x00000000, 0x01030003, 0x00000060 -> pair_count=2, err_count=0, no mismatch pulse.
REQ-033 Same stream with the third word corrupted to 0x01030002 -> one mismatch pulse after the fourth accept, err_count=1, first_err=1, pair_count=2.
REQ-034 Same stream with in_valid low for 5 cycles between every word -> identical results to REQ-032.
REQ-035 clear pulsed coinciding with the second word, then the full four-word stream -> word discarded, in_ready=0 one cycle, final pair_count=2, err_count=0.
REQ-036 reset pulsed after the first word, then the four-word stream -> pair_count=2, err_count=0.
REQ-037 err_count forced near saturation by 70000 corrupted samples -> err_count holds 16'hFFFF, mismatch still pulses per bad sample.
